// File: rtl/button_pkg.sv
// Shared button constants: resolver bit order, key codes, event types, and
// helpers mapping between one-hot levels and key codes.
package button_pkg;

    localparam int BTN_W = 9;

    // Bit positions in the resolved button vector (bit 8 = b0).
    localparam int BTN_B0    = 8;
    localparam int BTN_B1    = 7;
    localparam int BTN_B2    = 6;
    localparam int BTN_B3    = 5;
    localparam int BTN_ENTER = 4;
    localparam int BTN_LEFT  = 3;
    localparam int BTN_RIGHT = 2;
    localparam int BTN_UP    = 1;
    localparam int BTN_DOWN  = 0;

    localparam logic [3:0] KEY_B0    = 4'd0;
    localparam logic [3:0] KEY_B1    = 4'd1;
    localparam logic [3:0] KEY_B2    = 4'd2;
    localparam logic [3:0] KEY_B3    = 4'd3;
    localparam logic [3:0] KEY_ENTER = 4'd4;
    localparam logic [3:0] KEY_LEFT  = 4'd5;
    localparam logic [3:0] KEY_RIGHT = 4'd6;
    localparam logic [3:0] KEY_UP    = 4'd7;
    localparam logic [3:0] KEY_DOWN  = 4'd8;

    localparam logic [1:0] EV_PRESS   = 2'd0;
    localparam logic [1:0] EV_HOLD    = 2'd1;
    localparam logic [1:0] EV_REPEAT  = 2'd2;
    localparam logic [1:0] EV_RELEASE = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_PRESSED = 2'd1,
        S_HELD    = 2'd2
    } enc_state_e;

    typedef struct packed {
        logic [3:0] code;
        logic [1:0] etype;
    } key_event_t;

    function automatic logic is_onehot(input logic [BTN_W-1:0] lvl);
        return (lvl != '0) && ((lvl & (lvl - 1'b1)) == '0);
    endfunction

    function automatic logic [BTN_W-1:0] key_mask(input logic [3:0] code);
        logic [BTN_W-1:0] m;
        m = '0;
        for (int i = 0; i < BTN_W; i++)
            if (code == 4'(BTN_W - 1 - i)) m[i] = 1'b1;
        return m;
    endfunction

    // Only meaningful for one-hot input.
    function automatic logic [3:0] key_code(input logic [BTN_W-1:0] lvl);
        logic [3:0] c;
        c = '0;
        for (int i = 0; i < BTN_W; i++)
            if (lvl[i]) c = 4'(BTN_W - 1 - i);
        return c;
    endfunction

endpackage

// File: rtl/button_event_fifo.sv
// Small synchronous event FIFO; a push into a full FIFO is accepted only when
// a pop happens in the same cycle.
module button_event_fifo #(
    parameter int DEPTH = 4,
    parameter int DW    = 6
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          push,
    input  logic [DW-1:0] wdata,
    input  logic          pop,
    output logic [DW-1:0] rdata,
    output logic          full,
    output logic          empty
);
    localparam int AW = $clog2(DEPTH);

    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] mem_d [DEPTH];
    logic [AW:0]   wr_ptr_q, wr_ptr_d;
    logic [AW:0]   rd_ptr_q, rd_ptr_d;
    logic          do_push, do_pop;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign rdata   = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) begin
            mem_d[wr_ptr_q[AW-1:0]] = wdata;
            wr_ptr_d                = wr_ptr_q + 1'b1;
        end
        if (do_pop)
            rd_ptr_d = rd_ptr_q + 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

endmodule

// File: rtl/button_event_encoder.sv
// Turns resolved one-hot button levels into PRESS/HOLD/REPEAT/RELEASE events
// queued for the UI. REPEAT generation is enabled by BUTTON_EVENT_REPEAT_EN.
module button_event_encoder
    import button_pkg::*;
#(
    parameter int HOLD_CYCLES   = 27_000_000,
    parameter int REPEAT_CYCLES = 5_400_000,
    parameter int CNT_W         = 25,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [BTN_W-1:0] button_in,
    output logic             ev_valid,
    output logic [3:0]       ev_code,
    output logic [1:0]       ev_type,
    input  logic             ev_ready,
    output logic             overflow,
    input  logic             overflow_clr,
    output logic             input_err
);
    localparam int MAX_CYC = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);

    if ((64'(MAX_CYC - 1) >> CNT_W) != 64'd0) begin : g_cnt_w_check
        $error("CNT_W too narrow for HOLD_CYCLES/REPEAT_CYCLES");
    end

    enc_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       cur_q, cur_d;
    logic             overflow_q, overflow_d;
    logic             input_err_q, input_err_d;

    logic       push, pop, fifo_full, fifo_empty;
    key_event_t push_ev, head_ev;
    logic       multi_hot;

    assign multi_hot = (button_in != '0) && !is_onehot(button_in);

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        cur_d         = cur_q;
        input_err_d   = 1'b0;
        push          = 1'b0;
        push_ev.code  = cur_q;
        push_ev.etype = EV_PRESS;
        case (state_q)
            S_IDLE: begin
                if (is_onehot(button_in)) begin
                    cur_d        = key_code(button_in);
                    push         = 1'b1;
                    push_ev.code = key_code(button_in);
                    cnt_d        = '0;
                    state_d      = S_PRESSED;
                end else begin
                    input_err_d = multi_hot;
                end
            end
            S_PRESSED, S_HELD: begin
                // Anything other than the latched key alone ends the press.
                if (button_in != key_mask(cur_q)) begin
                    push          = 1'b1;
                    push_ev.etype = EV_RELEASE;
                    input_err_d   = multi_hot;
                    cnt_d         = '0;
                    state_d       = S_IDLE;
                end else if (state_q == S_PRESSED) begin
                    if (cnt_q == HOLD_LAST) begin
                        push          = 1'b1;
                        push_ev.etype = EV_HOLD;
                        cnt_d         = '0;
                        state_d       = S_HELD;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end else begin
`ifdef BUTTON_EVENT_REPEAT_EN
                    if (cnt_q == CNT_W'(REPEAT_CYCLES - 1)) begin
                        push          = 1'b1;
                        push_ev.etype = EV_REPEAT;
                        cnt_d         = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
`else
                    cnt_d = cnt_q;
`endif
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign pop = ev_valid & ev_ready;

    // A drop sets the flag even when a clear is requested in the same cycle.
    always_comb begin
        overflow_d = overflow_q;
        if (push && fifo_full && !pop)
            overflow_d = 1'b1;
        else if (overflow_clr)
            overflow_d = 1'b0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            cur_q       <= '0;
            overflow_q  <= 1'b0;
            input_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cur_q       <= cur_d;
            overflow_q  <= overflow_d;
            input_err_q <= input_err_d;
        end
    end

    button_event_fifo #(
        .DEPTH (FIFO_DEPTH),
        .DW    ($bits(key_event_t))
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (push),
        .wdata   (push_ev),
        .pop     (pop),
        .rdata   (head_ev),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign ev_valid  = ~fifo_empty;
    assign ev_code   = head_ev.code;
    assign ev_type   = head_ev.etype;
    assign overflow  = overflow_q;
    assign input_err = input_err_q;

endmodule
